// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in parallel-out receiver.
//   state_t      : receiver FSM states (S_PARITY reachable only with PARITY_CHECK_EN)
//   PARITY_EVEN  : XOR over {word, parity bit} that marks a good frame
//   cnt_width()  : width of a counter that must hold 0..w
package sipo_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input side and parallel handshake side of the receiver.
//   SI, SE, CLR : serial data, shift enable, synchronous clear (driven by master)
//   P, P_VALID  : registered parallel word and its valid flag (driven by slave)
//   P_READY     : consumer accept (driven by master)
//   OVERRUN     : sticky dropped-word flag, PERR : parity error of current P
// Modports: master = link/consumer side, slave = receiver.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             SI;
  logic             SE;
  logic             CLR;
  logic             P_READY;
  logic [WIDTH-1:0] P;
  logic             P_VALID;
  logic             OVERRUN;
  logic             PERR;

  modport master (
    output SI, SE, CLR, P_READY,
    input  P, P_VALID, OVERRUN, PERR
  );

  modport slave (
    input  SI, SE, CLR, P_READY,
    output P, P_VALID, OVERRUN, PERR
  );

endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register and bit counter of the receiver.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear of SR and CNT (wins over shift_en)
//   shift_en   : shift SI into SR and advance CNT
//   si         : serial data
//   sr         : current shift register contents
//   sr_next    : SR as it will look after this edge's shift (final-bit word)
//   done       : this edge shifts the last bit of a word; CNT wraps to 0
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] sr_next,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_next = {sr[WIDTH-2:0], si};
    end else begin : g_lsb
      assign sr_next = {si, sr[WIDTH-1:1]};
    end
  endgenerate

  assign done = shift_en && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= sr_next;
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out receiver with valid/ready delivery.
//   clk, reset : clock, async active-low reset
//   bus        : sipo_deserializer_if slave (SI/SE/CLR in, P/P_VALID/OVERRUN/PERR out,
//                P_READY in)
// Parameters: WIDTH (>= 2), MSB_FIRST (1: first bit lands in P[WIDTH-1]).
// Build option: define PARITY_CHECK_EN to expect an even-parity bit after each
// word; the word is then delivered on the parity edge and PERR reports the check.
// Without it PERR is always 0.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               reset,
  sipo_deserializer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr, sr_next;
  logic             done;
  logic             shift_en;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             load_perr;
  logic [WIDTH-1:0] p_q;
  logic             p_valid_q;
  logic             overrun_q;
  logic             perr_q;

  // The parity bit must not enter SR: the completed word is held there until
  // the parity edge delivers it.
  assign shift_en = bus.SE && (state_q != S_PARITY);

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.CLR),
    .shift_en (shift_en),
    .si       (bus.SI),
    .sr       (sr),
    .sr_next  (sr_next),
    .done     (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_word = sr_next;
    load_perr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.SE) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (done) begin
`ifdef PARITY_CHECK_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
          load    = 1'b1;
`endif
        end
      end
      S_PARITY: begin
        if (bus.SE) begin
          state_d   = S_IDLE;
          load      = 1'b1;
          load_word = sr;
`ifdef PARITY_CHECK_EN
          load_perr = (^{sr, bus.SI}) ^ PARITY_EVEN;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.CLR) begin
      state_d = S_IDLE;
      load    = 1'b0;
    end
  end

  // A completing word is taken if the slot is empty or being accepted on the
  // same edge; otherwise it is dropped and the overrun flag latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else if (bus.CLR) begin
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else if (load) begin
      if (!p_valid_q || bus.P_READY) begin
        p_q       <= load_word;
        p_valid_q <= 1'b1;
        perr_q    <= load_perr;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (p_valid_q && bus.P_READY) begin
      p_valid_q <= 1'b0;
      perr_q    <= 1'b0;
    end
  end

  assign bus.P       = p_q;
  assign bus.P_VALID = p_valid_q;
  assign bus.OVERRUN = overrun_q;
  assign bus.PERR    = perr_q;

endmodule
